// File: rtl/ALU_package.sv
// rtl/ALU_package.sv - shared ALU opcode and width definitions
package ALU_package;

  localparam int OPND_W = 4;
  localparam int RES_W  = 5;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    INV = 2'b10,
    ORB = 2'b11
  } alu_op_e;

endpackage

// File: rtl/ALU_4_bit.sv
// rtl/ALU_4_bit.sv - 4-bit signed ALU with a registered 5-bit result
module ALU_4_bit
  import ALU_package::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  alu_op_e                  opcode,
  input  logic signed [OPND_W-1:0] A,
  input  logic signed [OPND_W-1:0] B,
  output logic signed [RES_W-1:0]  C
);

  logic signed [RES_W-1:0] a_ext;
  logic signed [RES_W-1:0] b_ext;
  logic signed [RES_W-1:0] c_d;
  logic signed [RES_W-1:0] c_q;

  // Operands widen to the result width first so add/sub never overflow.
  always_comb begin
    a_ext = {A[OPND_W-1], A};
    b_ext = {B[OPND_W-1], B};
    c_d   = '0;
    case (opcode)
      ADD: c_d = a_ext + b_ext;
      SUB: c_d = a_ext - b_ext;
      INV: c_d = ~a_ext;
      ORB: c_d = {{(RES_W-1){1'b0}}, |B};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) c_q <= '0;
    else     c_q <= c_d;
  end

  assign C = c_q;

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU_4_bit among requesters
module alu_arbiter
  import ALU_package::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0][1:0]              req_opcode,
  input  logic signed [NUM_REQ-1:0][OPND_W-1:0] req_A,
  input  logic signed [NUM_REQ-1:0][OPND_W-1:0] req_B,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic                                 rsp_valid,
  input  logic                                 rsp_ready,
  output logic [ID_W-1:0]                      rsp_id,
  output logic signed [RES_W-1:0]              rsp_C,
  output logic [7:0]                           ops_done
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [ID_W-1:0]   id_q, id_d;
  alu_op_e           op_q, op_d;
  logic [OPND_W-1:0] a_q, a_d;
  logic [OPND_W-1:0] b_q, b_d;
  logic [7:0]        ops_done_q, ops_done_d;

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic signed [RES_W-1:0] alu_c;

  // Scan downward so the last hit kept is the nearest index after 'last'.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    last);
    logic [ID_W:0] res;
    int            idx;
    res = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (valid[idx]) res = {1'b1, ID_W'(idx)};
    end
    return res;
  endfunction

  always_comb begin
    {grant_found, grant_idx} = rr_pick(req_valid, last_grant_q);
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    ops_done_d   = ops_done_q;
    req_ready    = '0;
    rsp_valid    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_found && rst) begin
          req_ready    = NUM_REQ'(1) << grant_idx;
          op_d         = alu_op_e'(req_opcode[grant_idx]);
          a_d          = req_A[grant_idx];
          b_d          = req_B[grant_idx];
          id_d         = grant_idx;
          last_grant_d = grant_idx;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: state_d = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          ops_done_d = ops_done_q + 8'd1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      op_q         <= ADD;
      a_q          <= '0;
      b_q          <= '0;
      ops_done_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      ops_done_q   <= ops_done_d;
    end
  end

  // The ALU samples the held operand registers every cycle, so C is stable in RESP.
  ALU_4_bit u_alu (
    .clk    (clk),
    .rst    (~rst),
    .opcode (op_q),
    .A      (a_q),
    .B      (b_q),
    .C      (alu_c)
  );

  assign rsp_id   = (state_q == S_RESP) ? id_q  : '0;
  assign rsp_C    = (state_q == S_RESP) ? alu_c : '0;
  assign ops_done = ops_done_q;

endmodule
